// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: job control, input-beat and result handshakes for sum_accumulator.
`default_nettype none

interface sum_accumulator_if #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
);
   logic             clr;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_sum;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_total;
   logic [CNT_W-1:0] out_count;
   logic             ovf;
   logic             busy;

   modport master (
      output clr, start, len, in_valid, in_sum, out_ready,
      input  in_ready, out_valid, out_total, out_count, ovf, busy
   );

   modport slave (
      input  clr, start, len, in_valid, in_sum, out_ready,
      output in_ready, out_valid, out_total, out_count, ovf, busy
   );
endinterface

`default_nettype wire

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator: accumulates a job of len 32-bit sums into an ACC_W total.
// Macro SUM_ACC_SAT_EN: saturate instead of wrap on overflow.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sum_accumulator #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   sum_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W-1:0] len_q,   len_d;
   logic             ovf_q,   ovf_d;

   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic [CNT_W-1:0] cnt_inc;

   // One extra bit on the adder exposes the carry out of the accumulator.
   assign sum_ext = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, bus.in_sum};
   assign carry   = sum_ext[ACC_W];
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;

      if (bus.clr) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  len_d   = bus.len;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = (bus.len == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (bus.in_valid) begin
`ifdef SUM_ACC_SAT_EN
                  acc_d = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
                  acc_d = sum_ext[ACC_W-1:0];
`endif
                  ovf_d = ovf_q | carry;
                  cnt_d = cnt_inc;
                  if (cnt_inc == len_q) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_total = acc_q;
   assign bus.out_count = cnt_q;
   assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: randomized jobs checked against an arithmetic reference model.
`default_nettype none

module tb_sum_accumulator;
   localparam int ACC_W = 40;
   localparam int CNT_W = 8;
   localparam int SW    = 33;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sum_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) ifa ();
   sum_accumulator_if #(.ACC_W(SW),    .CNT_W(CNT_W)) ifb ();

   sum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   sum_accumulator #(.ACC_W(SW), .CNT_W(CNT_W)) u_dut_narrow (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact sum of accepted beats reduced to w bits.
   function automatic logic [63:0] ref_total(input logic [63:0] s, input int w);
      logic [63:0] lim;
      lim = (64'd1 << w) - 64'd1;
`ifdef SUM_ACC_SAT_EN
      return (s > lim) ? lim : s;
`else
      return s & lim;
`endif
   endfunction

   function automatic logic ref_ovf(input logic [63:0] s, input int w);
      return (s >> w) != 64'd0;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic job(input int n, input int vmode, input int smode, input int hold);
      logic [63:0] s;
      logic [5:0]  vpat;
      int          cnt;
      int          cyc;
      logic        v;
      logic [31:0] d;
      s    = '0;
      cnt  = 0;
      cyc  = 0;
      vpat = 6'b101001;
      ifa.start = 1'b1;
      ifa.len   = n[CNT_W-1:0];
      step;
      ifa.start = 1'b0;
      while (cnt < n && cyc < 600) begin
         check("in_ready_accum", {63'd0, ifa.in_ready}, 64'd1);
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'($urandom_range(0, 1)) : vpat[cyc % 6];
         d = (smode == 0) ? $urandom : (smode == 1) ? 32'(cnt + 1) :
             (smode == 2) ? 32'hFFFF_FFFF : 32'd7;
         ifa.in_valid = v;
         ifa.in_sum   = d;
         if ($urandom_range(0, 3) == 0) begin
            ifa.start = 1'b1;
            ifa.len   = 8'($urandom);
         end
         step;
         ifa.start = 1'b0;
         if (v) begin
            s = s + {32'd0, d};
            cnt++;
         end
         cyc++;
      end
      ifa.in_valid = 1'b0;
      check("done_out_valid", {63'd0, ifa.out_valid}, 64'd1);
      check("done_busy",      {63'd0, ifa.busy},      64'd1);
      check("done_in_ready",  {63'd0, ifa.in_ready},  64'd0);
      check("done_total",     64'(ifa.out_total),     ref_total(s, ACC_W));
      check("done_count",     64'(ifa.out_count),     64'(n));
      check("done_ovf",       {63'd0, ifa.ovf},       {63'd0, ref_ovf(s, ACC_W)});
      for (int h = 0; h < hold; h++) begin
         ifa.out_ready = 1'b0;
         ifa.start     = 1'($urandom_range(0, 1));
         ifa.len       = 8'($urandom);
         ifa.in_valid  = 1'($urandom_range(0, 1));
         ifa.in_sum    = $urandom;
         step;
         check("hold_out_valid", {63'd0, ifa.out_valid}, 64'd1);
         check("hold_total",     64'(ifa.out_total),     ref_total(s, ACC_W));
         check("hold_count",     64'(ifa.out_count),     64'(n));
      end
      ifa.start     = 1'b0;
      ifa.in_valid  = 1'b0;
      ifa.out_ready = 1'b1;
      step;
      ifa.out_ready = 1'b0;
      check("release_out_valid", {63'd0, ifa.out_valid}, 64'd0);
      check("release_busy",      {63'd0, ifa.busy},      64'd0);
   endtask

   initial begin
      logic [63:0] sb;
      rst_n = 1'b0;
      {ifa.clr, ifa.start, ifa.in_valid, ifa.out_ready} = '0;
      ifa.len = '0; ifa.in_sum = '0;
      {ifb.clr, ifb.start, ifb.in_valid, ifb.out_ready} = '0;
      ifb.len = '0; ifb.in_sum = '0;
      #12;
      check("rst_in_ready",  {63'd0, ifa.in_ready},  64'd0);
      check("rst_out_valid", {63'd0, ifa.out_valid}, 64'd0);
      check("rst_total",     64'(ifa.out_total),     64'd0);
      check("rst_count",     64'(ifa.out_count),     64'd0);
      check("rst_ovf",       {63'd0, ifa.ovf},       64'd0);
      check("rst_busy",      {63'd0, ifa.busy},      64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step;

      job(4, 0, 1, 2);
      job(3, 2, 2, 1);
      job(0, 0, 0, 5);

      // Abort with a beat presented in the same cycle.
      ifa.start = 1'b1; ifa.len = 8'd5;
      step;
      ifa.start = 1'b0; ifa.in_valid = 1'b1; ifa.in_sum = $urandom;
      step;
      step;
      ifa.clr = 1'b1;
      step;
      ifa.clr = 1'b0; ifa.in_valid = 1'b0;
      check("clr_busy",     {63'd0, ifa.busy},     64'd0);
      check("clr_in_ready", {63'd0, ifa.in_ready}, 64'd0);
      check("clr_count",    64'(ifa.out_count),    64'd0);
      check("clr_total",    64'(ifa.out_total),    64'd0);
      check("clr_ovf",      {63'd0, ifa.ovf},      64'd0);
      step;
      check("clr_stay_idle", {63'd0, ifa.busy},    64'd0);
      job(1, 0, 3, 1);

      for (int j = 0; j < 10; j++) begin
         job($urandom_range(0, 20), $urandom_range(0, 1), 0, $urandom_range(0, 3));
      end

      // Asynchronous reset in the middle of a clock period.
      ifa.start = 1'b1; ifa.len = 8'd5;
      step;
      ifa.start = 1'b0; ifa.in_valid = 1'b1; ifa.in_sum = 32'd9;
      step;
      step;
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy",      {63'd0, ifa.busy},      64'd0);
      check("arst_in_ready",  {63'd0, ifa.in_ready},  64'd0);
      check("arst_out_valid", {63'd0, ifa.out_valid}, 64'd0);
      check("arst_total",     64'(ifa.out_total),     64'd0);
      check("arst_count",     64'(ifa.out_count),     64'd0);
      ifa.in_valid = 1'b0; ifa.start = 1'b1; ifa.len = 8'd3;
      step;
      step;
      check("arst_start_ignored", {63'd0, ifa.busy}, 64'd0);
      ifa.start = 1'b0;
      #2;
      rst_n = 1'b1;
      step;
      check("arst_post_busy",  {63'd0, ifa.busy},  64'd0);
      check("arst_post_count", 64'(ifa.out_count), 64'd0);

      // Narrow accumulator overflow.
      sb = 64'd3 * 64'h0000_0000_FFFF_FFFF;
      ifb.start = 1'b1; ifb.len = 8'd3;
      step;
      ifb.start = 1'b0; ifb.in_valid = 1'b1; ifb.in_sum = 32'hFFFF_FFFF;
      step;
      step;
      step;
      ifb.in_valid = 1'b0;
      check("narrow_out_valid", {63'd0, ifb.out_valid}, 64'd1);
      check("narrow_total",     64'(ifb.out_total),     ref_total(sb, SW));
      check("narrow_count",     64'(ifb.out_count),     64'd3);
      check("narrow_ovf",       {63'd0, ifb.ovf},       {63'd0, ref_ovf(sb, SW)});
      ifb.out_ready = 1'b1;
      step;
      ifb.out_ready = 1'b0;
      check("narrow_release_busy", {63'd0, ifb.busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
